// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Bundles the host update inputs and the display drive outputs of the
//   4-digit 7-segment scan controller.
//   Ports (all signals, directions seen from the slave/controller side):
//     hexIn[15:0]  in   new display value, digit k = hexIn[4k+3:4k]
//     dpIn[3:0]    in   new decimal-point bits, one per digit
//     enIn[3:0]    in   new digit enables (0 blanks that digit)
//     load         in   1-cycle strobe capturing hexIn/dpIn/enIn
//     pending      out  captured value not yet applied to the display
//     sel[1:0]     out  current digit index
//     nibble[3:0]  out  hex nibble of digit sel
//     dp           out  decimal-point bit of digit sel
//     an[3:0]      out  anode enables, one-hot-active or all off
//     frameTick    out  1-cycle pulse at the start of each frame
interface seg7_scan_ctrl_if;
  logic [15:0] hexIn;
  logic [3:0]  dpIn;
  logic [3:0]  enIn;
  logic        load;
  logic        pending;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic        dp;
  logic [3:0]  an;
  logic        frameTick;

  modport master (
    output hexIn, dpIn, enIn, load,
    input  pending, sel, nibble, dp, an, frameTick
  );

  modport slave (
    input  hexIn, dpIn, enIn, load,
    output pending, sel, nibble, dp, an, frameTick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit 7-segment display.
//   Each digit owns a slot of CLK_DIV cycles; the first BLANK_CYC cycles of
//   every slot keep all anodes off to suppress ghosting. Host updates are
//   captured into shadow registers and copied to the active registers only
//   at the frame boundary (sel 3->0), so a frame never mixes old and new data.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of seg7_scan_ctrl_if (host update + display drive)
//   Parameters:
//     CLK_DIV     cycles per digit slot (2..2^20)
//     BLANK_CYC   blanked cycles at the start of each slot (0..CLK_DIV-1)
//     AN_ACT_LOW  1: anodes active-low, 0: active-high
//
//   state | meaning
//   DIG0  | scanning digit 0 (frame start)
//   DIG1  | scanning digit 1
//   DIG2  | scanning digit 2
//   DIG3  | scanning digit 3; slot end here is the frame boundary
module seg7_scan_ctrl #(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 500,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int             PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  BLANK_P = PW'(BLANK_CYC);
  localparam logic [3:0]     AN_OFF  = AN_ACT_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digitE;

  digitE          digState, digNext;
  logic [PW-1:0]  prescale, prescaleNext;
  logic           slotEnd, frameEnd;

  logic [15:0] shadowHex, shadowHexNext;
  logic [3:0]  shadowDp,  shadowDpNext;
  logic [3:0]  shadowEn,  shadowEnNext;
  logic [15:0] activeHex, activeHexNext;
  logic [3:0]  activeDp,  activeDpNext;
  logic [3:0]  activeEn,  activeEnNext;
  logic        pendingQ,  pendingNext;

  logic        blankDone;
  logic [3:0]  anOneHot;
  logic [3:0]  nibbleNext, anNext;
  logic        dpNext;
  logic [3:0]  nibbleQ, anQ;
  logic        dpQ, frameTickQ;

  assign slotEnd      = (prescale == P_LAST);
  assign frameEnd     = slotEnd && (digState == DIG3);
  assign prescaleNext = slotEnd ? '0 : prescale + 1'b1;

  // Digit FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digState <= DIG0;
      prescale <= '0;
    end else begin
      digState <= digNext;
      prescale <= prescaleNext;
    end
  end

  // Digit FSM: next state, advancing once per slot
  always_comb begin
    digNext = digState;
    if (slotEnd) begin
      case (digState)
        DIG0:    digNext = DIG1;
        DIG1:    digNext = DIG2;
        DIG2:    digNext = DIG3;
        DIG3:    digNext = DIG0;
        default: digNext = DIG0;
      endcase
    end
  end

  // Double-buffered update. A load coinciding with the frame boundary goes
  // straight to the active set so it is not delayed by a whole frame.
  always_comb begin
    shadowHexNext = shadowHex;
    shadowDpNext  = shadowDp;
    shadowEnNext  = shadowEn;
    activeHexNext = activeHex;
    activeDpNext  = activeDp;
    activeEnNext  = activeEn;
    pendingNext   = pendingQ;
    if (frameEnd) begin
      pendingNext = 1'b0;
      if (bus.load) begin
        activeHexNext = bus.hexIn;
        activeDpNext  = bus.dpIn;
        activeEnNext  = bus.enIn;
      end else if (pendingQ) begin
        activeHexNext = shadowHex;
        activeDpNext  = shadowDp;
        activeEnNext  = shadowEn;
      end
    end else if (bus.load) begin
      shadowHexNext = bus.hexIn;
      shadowDpNext  = bus.dpIn;
      shadowEnNext  = bus.enIn;
      pendingNext   = 1'b1;
    end
  end

  // Blanking decision is taken on the prescaler value the outputs will
  // accompany, keeping an aligned with sel/nibble after registering.
  generate
    if (BLANK_CYC == 0) begin : gNoBlank
      assign blankDone = 1'b1;
    end else begin : gBlank
      assign blankDone = (prescaleNext >= BLANK_P);
    end
  endgenerate

  always_comb begin
    nibbleNext = activeHexNext[4*digNext +: 4];
    dpNext     = activeDpNext[digNext];
    anOneHot   = 4'b0000;
    if (blankDone && activeEnNext[digNext]) begin
      anOneHot = 4'b0001 << digNext;
    end
    anNext = AN_ACT_LOW ? ~anOneHot : anOneHot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowHex  <= '0;
      shadowDp   <= '0;
      shadowEn   <= '0;
      activeHex  <= '0;
      activeDp   <= '0;
      activeEn   <= '0;
      pendingQ   <= 1'b0;
      nibbleQ    <= '0;
      dpQ        <= 1'b0;
      anQ        <= AN_OFF;
      frameTickQ <= 1'b0;
    end else begin
      shadowHex  <= shadowHexNext;
      shadowDp   <= shadowDpNext;
      shadowEn   <= shadowEnNext;
      activeHex  <= activeHexNext;
      activeDp   <= activeDpNext;
      activeEn   <= activeEnNext;
      pendingQ   <= pendingNext;
      nibbleQ    <= nibbleNext;
      dpQ        <= dpNext;
      anQ        <= anNext;
      frameTickQ <= frameEnd;
    end
  end

  assign bus.pending   = pendingQ;
  assign bus.sel       = digState;
  assign bus.nibble    = nibbleQ;
  assign bus.dp        = dpQ;
  assign bus.an        = anQ;
  assign bus.frameTick = frameTickQ;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Directed bench for seg7_scan_ctrl with CLK_DIV=4, BLANK_CYC=1,
//   AN_ACT_LOW=1. pos tracks the position inside the 16-cycle frame
//   (sel = pos/4, prescaler = pos%4) as seen after each sampled edge.
module tb_seg7_scan_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pos;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(
    .CLK_DIV    (4),
    .BLANK_CYC  (1),
    .AN_ACT_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs set before the call are taken at the posedge;
  // outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pos = (pos + 1) % 16;
  endtask

  task automatic doLoad(input logic [15:0] hex, input logic [3:0] dpv, input logic [3:0] en);
    bus.hexIn = hex;
    bus.dpIn  = dpv;
    bus.enIn  = en;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] expSel;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'hF || bus.sel !== 2'd0 || bus.pending !== 1'b0 ||
        bus.nibble !== 4'h0 || bus.dp !== 1'b0 || bus.frameTick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an=%h sel=%0d pending=%b nibble=%h dp=%b tick=%b, required an=f sel=0 pending=0 nibble=0 dp=0 tick=0",
               bus.an, bus.sel, bus.pending, bus.nibble, bus.dp, bus.frameTick);
    end
    rst_n = 1'b1;
    pos = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      expSel = 2'(pos / 4);
      checks++;
      if (bus.an !== 4'hF) begin
        errors++;
        $display("FAIL idle_an: cycle %0d an=%h, required f", i, bus.an);
      end
      checks++;
      if (bus.sel !== expSel) begin
        errors++;
        $display("FAIL idle_sel: cycle %0d sel=%0d, required %0d", i, bus.sel, expSel);
      end
      checks++;
      if (bus.frameTick !== (pos == 0)) begin
        errors++;
        $display("FAIL idle_tick: cycle %0d frameTick=%b, required %b", i, bus.frameTick, (pos == 0));
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [1:0] s;
    logic [3:0] expAn;
    while (pos != 5) tick();
    doLoad(16'h4321, 4'b0100, 4'hF);
    while (pos != 0) begin
      checks++;
      if (bus.pending !== 1'b1) begin
        errors++;
        $display("FAIL pending_hold: pos %0d pending=%b, required 1", pos, bus.pending);
      end
      tick();
    end
    checks++;
    if (bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL pending_clear: pending=%b, required 0", bus.pending);
    end
    for (int i = 0; i < 16; i++) begin
      s = 2'(pos / 4);
      expAn = (pos % 4 == 0) ? 4'hF : ~(4'b0001 << s);
      checks++;
      if (bus.nibble !== 4'(s + 1) || bus.dp !== (s == 2'd2) || bus.an !== expAn) begin
        errors++;
        $display("FAIL scan_4321: pos %0d nibble=%h dp=%b an=%h, required nibble=%h dp=%b an=%h",
                 pos, bus.nibble, bus.dp, bus.an, 4'(s + 1), (s == 2'd2), expAn);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    while (pos != 2) tick();
    doLoad(16'hAAAA, 4'h0, 4'hF);
    while (pos != 6) tick();
    doLoad(16'h5555, 4'h0, 4'hF);
    while (pos != 0) begin
      checks++;
      if (bus.nibble === 4'hA) begin
        errors++;
        $display("FAIL no_aaaa_old: pos %0d nibble=%h, required not a", pos, bus.nibble);
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.nibble !== 4'h5) begin
        errors++;
        $display("FAIL last_wins: pos %0d nibble=%h, required 5", pos, bus.nibble);
      end
      tick();
    end
  endtask

  task automatic test_boundary_bypass();
    logic [1:0] s;
    logic [3:0] expNib;
    logic [3:0] expAn;
    logic [15:0] hexVal;
    hexVal = 16'h00F0;
    while (pos != 15) tick();
    doLoad(hexVal, 4'h0, 4'b1101);
    checks++;
    if (bus.pending !== 1'b0 || bus.nibble !== 4'h0) begin
      errors++;
      $display("FAIL bypass_apply: pending=%b nibble=%h, required pending=0 nibble=0", bus.pending, bus.nibble);
    end
    for (int i = 0; i < 16; i++) begin
      s = 2'(pos / 4);
      expNib = hexVal[4*s +: 4];
      if (pos % 4 == 0 || s == 2'd1) expAn = 4'hF;
      else expAn = ~(4'b0001 << s);
      checks++;
      if (bus.nibble !== expNib || bus.an !== expAn || bus.pending !== 1'b0) begin
        errors++;
        $display("FAIL bypass_scan: pos %0d nibble=%h an=%h pending=%b, required nibble=%h an=%h pending=0",
                 pos, bus.nibble, bus.an, bus.pending, expNib, expAn);
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    while (pos != 1) tick();
    doLoad(16'h1234, 4'hF, 4'hF);
    while (pos != 9) tick();
    checks++;
    if (bus.pending !== 1'b1 || bus.sel !== 2'd2 || bus.an !== 4'hB) begin
      errors++;
      $display("FAIL pre_reset: pending=%b sel=%0d an=%h, required pending=1 sel=2 an=b", bus.pending, bus.sel, bus.an);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.sel !== 2'd0 || bus.pending !== 1'b0 ||
        bus.nibble !== 4'h0 || bus.dp !== 1'b0 || bus.frameTick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%h sel=%0d pending=%b nibble=%h dp=%b tick=%b, required f 0 0 0 0 0",
               bus.an, bus.sel, bus.pending, bus.nibble, bus.dp, bus.frameTick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pos = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (bus.an !== 4'hF || bus.pending !== 1'b0 || bus.nibble !== 4'h0 || bus.sel !== 2'(pos / 4)) begin
        errors++;
        $display("FAIL post_reset: pos %0d an=%h pending=%b nibble=%h sel=%0d, required an=f pending=0 nibble=0 sel=%0d",
                 pos, bus.an, bus.pending, bus.nibble, bus.sel, pos / 4);
      end
    end
  endtask

  task automatic test_random_frames();
    int ticks;
    int badHot;
    int badBlank;
    logic [3:0] lit;
    ticks = 0;
    badHot = 0;
    badBlank = 0;
    for (int i = 0; i < 16000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.hexIn = 16'($urandom);
        bus.dpIn  = 4'($urandom);
        bus.enIn  = 4'($urandom);
        bus.load  = 1'b1;
      end else begin
        bus.load  = 1'b0;
      end
      tick();
      lit = ~bus.an;
      if ($countones(lit) > 1) badHot++;
      if (pos % 4 == 0 && bus.an !== 4'hF) badBlank++;
      if (bus.frameTick === 1'b1) ticks++;
    end
    bus.load = 1'b0;
    checks++;
    if (badHot != 0) begin
      errors++;
      $display("FAIL multi_hot: %0d cycles multi-hot, required 0", badHot);
    end
    checks++;
    if (badBlank != 0) begin
      errors++;
      $display("FAIL slot_blank: %0d slot starts lit, required 0", badBlank);
    end
    checks++;
    if (ticks != 1000) begin
      errors++;
      $display("FAIL tick_count: %0d frame ticks, required 1000", ticks);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pos = 0;
    rst_n = 1'b0;
    bus.hexIn = '0;
    bus.dpIn  = '0;
    bus.enIn  = '0;
    bus.load  = 1'b0;
    test_reset();
    test_load_midframe();
    test_back_to_back();
    test_boundary_bypass();
    test_reset_midframe();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
